replace_order_decoder_wide: RTL and testbench
=============================================

# replace_order_decoder_wide

Multi-lane successor to the byte-serial Replace Order decoder. It accepts an ITCH byte stream `LANES` bytes per beat, with message boundaries at any lane. It tracks framing of all known message types and extracts 'U' (Replace Order) fields. Decoded results are presented through a one-entry ready/valid output register to the order-book update stage. Sync-loss and overflow events are flagged instead of silently mis-parsing.

## Interface
- `LANES`, 4: bytes per beat; legal values 1, 2, 4, 8.
- `MSG_TYPE`, 8'h55: type byte decoded by this block ('U').
- `MSG_LENGTH`, 27: total 'U' length in bytes, including type byte and 2 reserved bytes.
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Asynchronous, active-low.
- `data_in`  in  8*LANES  stream bytes. Lane 0 = bits [7:0] = earliest byte.
- `valid_in`  in  1  beat valid. When high, all LANES bytes are valid. Gaps (low) stall parsing with no error.
- `sof_in`  in  1  qualified by `valid_in`: lane 0 of this beat is a message type byte. Used for resync.
- `out_ready`  in  1  consumer accepts result.
- `out_valid`  out  1  result held until accepted.
- `old_order_ref`  out  64  message bytes 1-8, big-endian.
- `new_order_ref`  out  64  message bytes 9-16, big-endian.
- `shares`  out  32  message bytes 17-20, big-endian.
- `price`  out  32  message bytes 21-24, big-endian.
- `desync_err`  out  1  one-cycle pulse.
- `overflow_err`  out  1  one-cycle pulse.
- `replace_count`  out  32  accepted-to-output 'U' messages, saturating.

## Operation
- Length table: 'A' 36, 'X' 23, 'U' 27, 'D' 9, 'E' 30, 'P' 40. Any other type byte is unknown.
- Because minimum length 9 exceeds max LANES 8, a beat holds at most one message boundary. The implementation may rely on this.
- States: SYNC, LOST. Reset enters SYNC with pos=0, expecting a type byte at lane 0 of the first valid beat.
- SYNC, per beat:
  - Lanes are walked in order. Each lane consumes byte offset `pos` of the current message.
  - At pos=0, the byte is latched as type and length `cur_len` comes from the table.
  - When pos reaches `cur_len-1`, pos wraps to 0, so the next lane is a type byte.
  - 'U' payload bytes at offsets 1-24 are written into a shadow field register. Offsets 25-26 are ignored.
- Completion: on the last 'U' byte (offset 26), the shadow is transferred to the output register the same edge.
  - Transfer occurs if `out_valid`=0 or `out_ready`=1.
  - Otherwise the new result is dropped, the old result is held, and `overflow_err` pulses.
- Unknown type byte in SYNC: `desync_err` pulses, state goes to LOST, and the remaining lanes are discarded.
- LOST: all beats are discarded until `valid_in && sof_in`. That beat is parsed in SYNC from lane 0 with pos=0, with no extra pulse.
- `sof_in` in SYNC with pos≠0 at beat start: `desync_err` pulses, the partial message is abandoned (shadow not transferred), and parsing restarts at lane 0.
- `sof_in` with pos=0 is consistent and has no effect.
- Handshake: `out_valid` falls on `out_valid && out_ready` unless a new completion loads the same cycle. Fields stay stable while `out_valid`=1.
- `replace_count` increments on each load into the output register and saturates at 32'hFFFFFFFF.

## Timing
- Reset values: `out_valid`=0, all fields=0, `desync_err`=0, `overflow_err`=0, `replace_count`=0, pos=0, state SYNC.
- Reset mid-message discards the partial message and any held result.
- Latency: `out_valid` rises the cycle after the edge sampling the beat containing offset 26.
- Error pulses are registered and last exactly one cycle, one cycle after the offending beat.
- `valid_in`=0 cycles leave all state unchanged, including pos, type, and shadow.
- `out_ready` is never required for parsing to continue. The block never back-pressures input.
- Simultaneous accept and completion in one cycle: new result loads, `out_valid` stays 1, no overflow.

## Test plan
- LANES=4, single 'U' at reset alignment:
  - Stimulus: old=64'h0102030405060708, new=64'h1112131415161718, shares=32'h64, price=32'h186A0, plus 2 reserved bytes, in 7 beats. Beat 7 lane 3 = 'D' followed by a 9-byte D.
  - Required: one `out_valid` with exact fields, no errors, `replace_count`=1.
- Back-to-back mixed stream, LANES=8: 'A'(36), 'U', 'X'(23), 'U', with `out_ready`=1.
  - Required: exactly 2 results, each field correct, boundaries at lanes 4, 7, 6.
- `out_ready`=0 through two completed 'U' messages.
  - Required: first result held, `overflow_err` one pulse at second completion, `replace_count`=1. Raising `out_ready` drops `out_valid` next cycle.
- Unknown type 8'h7A at lane 2.
  - Required: `desync_err` pulse, no outputs until `sof_in` beat. The following 'U' decodes correctly.
- `sof_in` asserted at byte offset 12 of a 'U'.
  - Required: `desync_err` pulse, partial discarded, new message from lane 0 decodes.
- Gaps: `valid_in` low 3 cycles between every beat of a 'U', then async `rst` low mid-second message.
  - Required: first result correct, all outputs 0 immediately on reset.

Source files
------------

// File: rtl/replace_order_decoder_wide_if.sv
// Stream-in / result-out bundle for the wide Replace Order decoder.
interface replace_order_decoder_wide_if #(
    parameter int LANES = 4
);
    logic [8*LANES-1:0] data_in;
    logic               valid_in;
    logic               sof_in;
    logic               out_ready;
    logic               out_valid;
    logic [63:0]        old_order_ref;
    logic [63:0]        new_order_ref;
    logic [31:0]        shares;
    logic [31:0]        price;
    logic               desync_err;
    logic               overflow_err;
    logic [31:0]        replace_count;

    modport slave (
        input  data_in, valid_in, sof_in, out_ready,
        output out_valid, old_order_ref, new_order_ref, shares, price,
               desync_err, overflow_err, replace_count
    );

    modport master (
        output data_in, valid_in, sof_in, out_ready,
        input  out_valid, old_order_ref, new_order_ref, shares, price,
               desync_err, overflow_err, replace_count
    );
endinterface

// File: rtl/replace_order_decoder_wide.sv
// Multi-lane ITCH framer; extracts 'U' fields into a one-entry ready/valid result register.
module replace_order_decoder_wide_lane #(
    parameter logic [7:0] MSG_TYPE   = 8'h55,
    parameter int         MSG_LENGTH = 27
) (
    input  logic [5:0] i_pos,
    input  logic [5:0] i_len,
    input  logic [7:0] i_type,
    input  logic       i_lost,
    input  logic [7:0] i_byte,
    output logic [5:0] o_pos,
    output logic [5:0] o_len,
    output logic [7:0] o_type,
    output logic       o_lost,
    output logic       o_wr,
    output logic [4:0] o_slot,
    output logic       o_done,
    output logic       o_unk
);
    logic [5:0] w_len;

    function automatic logic [5:0] len_of(input logic [7:0] t);
        logic [5:0] l;
        if (t == MSG_TYPE) l = 6'(MSG_LENGTH);
        else begin
            case (t)
                8'h41:   l = 6'd36;
                8'h58:   l = 6'd23;
                8'h55:   l = 6'd27;
                8'h44:   l = 6'd9;
                8'h45:   l = 6'd30;
                8'h50:   l = 6'd40;
                default: l = 6'd0;
            endcase
        end
        return l;
    endfunction

    always_comb begin
        o_pos  = i_pos;
        o_len  = i_len;
        o_type = i_type;
        o_lost = i_lost;
        o_wr   = 1'b0;
        o_slot = '0;
        o_done = 1'b0;
        o_unk  = 1'b0;
        w_len  = len_of(i_byte);
        if (!i_lost) begin
            if (i_pos == 6'd0) begin
                if (w_len == 6'd0) begin
                    o_unk  = 1'b1;
                    o_lost = 1'b1;
                end else begin
                    o_type = i_byte;
                    o_len  = w_len;
                    o_pos  = 6'd1;
                end
            end else begin
                // Offsets 1..24 carry the four fields; 25..26 are reserved.
                if (i_type == MSG_TYPE && i_pos <= 6'd24) begin
                    o_wr   = 1'b1;
                    o_slot = 5'(i_pos - 6'd1);
                end
                if (i_pos == i_len - 6'd1) begin
                    o_pos  = 6'd0;
                    o_done = (i_type == MSG_TYPE);
                end else begin
                    o_pos = i_pos + 6'd1;
                end
            end
        end
    end
endmodule

module replace_order_decoder_wide #(
    parameter int         LANES      = 4,
    parameter logic [7:0] MSG_TYPE   = 8'h55,
    parameter int         MSG_LENGTH = 27
) (
    input  logic                         clk,
    input  logic                         rst,
    replace_order_decoder_wide_if.slave  bus
);
    typedef enum logic {SYNC = 1'b0, LOST = 1'b1} state_t;

    typedef struct packed {
        logic [63:0] old_ref;
        logic [63:0] new_ref;
        logic [31:0] shares;
        logic [31:0] price;
    } res_t;

    state_t                  r_state, w_state_nxt;
    logic [5:0]              r_pos, r_len;
    logic [7:0]              r_type;
    logic [23:0][7:0]        r_shadow, w_shadow;
    res_t                    r_res;
    logic                    r_out_valid, r_desync, r_overflow;
    logic [31:0]             r_count;

    logic [LANES:0][5:0]     w_pos_c, w_len_c;
    logic [LANES:0][7:0]     w_type_c;
    logic [LANES:0]          w_lost_c;
    logic [LANES-1:0]        w_wr, w_done_l, w_unk_l;
    logic [LANES-1:0][4:0]   w_slot;
    logic                    w_active, w_slip, w_done, w_load, w_ovf, w_desync;

    // A beat is parsed in SYNC, or in LOST only when it carries sof.
    assign w_active    = bus.valid_in && (r_state == SYNC || bus.sof_in);
    assign w_slip      = bus.valid_in && bus.sof_in && r_state == SYNC && r_pos != 6'd0;
    assign w_pos_c[0]  = bus.sof_in ? 6'd0 : r_pos;
    assign w_len_c[0]  = r_len;
    assign w_type_c[0] = r_type;
    assign w_lost_c[0] = !w_active;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            replace_order_decoder_wide_lane #(
                .MSG_TYPE  (MSG_TYPE),
                .MSG_LENGTH(MSG_LENGTH)
            ) u_lane (
                .i_pos (w_pos_c[g]),
                .i_len (w_len_c[g]),
                .i_type(w_type_c[g]),
                .i_lost(w_lost_c[g]),
                .i_byte(bus.data_in[8*g +: 8]),
                .o_pos (w_pos_c[g+1]),
                .o_len (w_len_c[g+1]),
                .o_type(w_type_c[g+1]),
                .o_lost(w_lost_c[g+1]),
                .o_wr  (w_wr[g]),
                .o_slot(w_slot[g]),
                .o_done(w_done_l[g]),
                .o_unk (w_unk_l[g])
            );
        end
    endgenerate

    always_comb begin
        w_shadow = r_shadow;
        for (int l = 0; l < LANES; l++) begin
            if (w_wr[l]) w_shadow[5'd23 - w_slot[l]] = bus.data_in[8*l +: 8];
        end
    end

    assign w_done   = |w_done_l;
    assign w_load   = w_done && (!r_out_valid || bus.out_ready);
    assign w_ovf    = w_done && r_out_valid && !bus.out_ready;
    assign w_desync = w_slip || (|w_unk_l);

    always_comb begin
        w_state_nxt = r_state;
        if (w_active) w_state_nxt = w_lost_c[LANES] ? LOST : SYNC;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= SYNC;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pos    <= '0;
            r_len    <= '0;
            r_type   <= '0;
            r_shadow <= '0;
        end else if (w_active) begin
            r_pos    <= w_pos_c[LANES];
            r_len    <= w_len_c[LANES];
            r_type   <= w_type_c[LANES];
            r_shadow <= w_shadow;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res       <= '0;
            r_out_valid <= 1'b0;
            r_desync    <= 1'b0;
            r_overflow  <= 1'b0;
            r_count     <= '0;
        end else begin
            r_desync   <= w_desync;
            r_overflow <= w_ovf;
            if (w_load) begin
                r_res       <= res_t'(w_shadow);
                r_out_valid <= 1'b1;
                if (r_count != 32'hFFFF_FFFF) r_count <= r_count + 32'd1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.old_order_ref = r_res.old_ref;
    assign bus.new_order_ref = r_res.new_ref;
    assign bus.shares        = r_res.shares;
    assign bus.price         = r_res.price;
    assign bus.desync_err    = r_desync;
    assign bus.overflow_err  = r_overflow;
    assign bus.replace_count = r_count;
endmodule

// File: tb/tb_replace_order_decoder_wide.sv
// Directed bench for replace_order_decoder_wide at LANES=4 and LANES=8.
module tb_replace_order_decoder_wide;
    localparam logic [63:0] U1_OLD = 64'h0102030405060708;
    localparam logic [63:0] U1_NEW = 64'h1112131415161718;
    localparam logic [31:0] U1_SH  = 32'h64;
    localparam logic [31:0] U1_PR  = 32'h186A0;
    localparam logic [63:0] U2_OLD = 64'hA1A2A3A4A5A6A7A8;
    localparam logic [63:0] U2_NEW = 64'hB1B2B3B4B5B6B7B8;
    localparam logic [31:0] U2_SH  = 32'hDEADBEEF;
    localparam logic [31:0] U2_PR  = 32'h12345678;

    typedef struct packed {
        logic [63:0] o;
        logic [63:0] n;
        logic [31:0] s;
        logic [31:0] p;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    replace_order_decoder_wide_if #(.LANES(4)) if4 ();
    replace_order_decoder_wide_if #(.LANES(8)) if8 ();

    replace_order_decoder_wide #(.LANES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
    replace_order_decoder_wide #(.LANES(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_ds4 = 0, n_ov4 = 0, n_ds8 = 0, n_ov8 = 0;
    res_t res4[$];
    res_t res8[$];
    logic [7:0] bq[$];

    always @(negedge clk) begin
        if (if4.out_valid && if4.out_ready)
            res4.push_back({if4.old_order_ref, if4.new_order_ref, if4.shares, if4.price});
        if (if8.out_valid && if8.out_ready)
            res8.push_back({if8.old_order_ref, if8.new_order_ref, if8.shares, if8.price});
        if (if4.desync_err)   n_ds4++;
        if (if4.overflow_err) n_ov4++;
        if (if8.desync_err)   n_ds8++;
        if (if8.overflow_err) n_ov8++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_res(input string tag, input res_t r, input logic [63:0] o, n,
                           input logic [31:0] s, p);
        chk({tag, ".old"}, r.o, o);
        chk({tag, ".new"}, r.n, n);
        chk({tag, ".sh"},  64'(r.s), 64'(s));
        chk({tag, ".pr"},  64'(r.p), 64'(p));
    endtask

    task automatic push_u(input logic [63:0] o, n, input logic [31:0] s, p);
        bq.push_back(8'h55);
        for (int i = 7; i >= 0; i--) bq.push_back(o[8*i +: 8]);
        for (int i = 7; i >= 0; i--) bq.push_back(n[8*i +: 8]);
        for (int i = 3; i >= 0; i--) bq.push_back(s[8*i +: 8]);
        for (int i = 3; i >= 0; i--) bq.push_back(p[8*i +: 8]);
        bq.push_back(8'hEE);
        bq.push_back(8'hEE);
    endtask

    task automatic push_msg(input logic [7:0] t, input int len);
        bq.push_back(t);
        for (int i = 1; i < len; i++) bq.push_back(8'(i));
    endtask

    // Pad with the head of a long 'P' so the tail never looks like a type byte.
    task automatic pad_to(input int n);
        if (bq.size() % n != 0) begin
            bq.push_back(8'h50);
            while (bq.size() % n != 0) bq.push_back(8'h00);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send4(input int nb, input bit sof, input int gap);
        logic [31:0] d;
        for (int b = 0; b < nb; b++) begin
            for (int l = 0; l < 4; l++) d[8*l +: 8] = bq.pop_front();
            if4.data_in = d; if4.valid_in = 1'b1; if4.sof_in = sof && (b == 0);
            @(posedge clk); #1;
            if4.valid_in = 1'b0; if4.sof_in = 1'b0;
            idle(gap);
        end
    endtask

    task automatic send8(input int nb, input bit sof);
        logic [63:0] d;
        for (int b = 0; b < nb; b++) begin
            for (int l = 0; l < 8; l++) d[8*l +: 8] = bq.pop_front();
            if8.data_in = d; if8.valid_in = 1'b1; if8.sof_in = sof && (b == 0);
            @(posedge clk); #1;
            if8.valid_in = 1'b0; if8.sof_in = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; #2; rst = 1'b1;
        bq.delete();
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, d0, o0;
        res_t r;
        if4.data_in = '0; if4.valid_in = 1'b0; if4.sof_in = 1'b0; if4.out_ready = 1'b1;
        if8.data_in = '0; if8.valid_in = 1'b0; if8.sof_in = 1'b0; if8.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst.valid4", 64'(if4.out_valid), 64'd0);
        chk("rst.old4",   if4.old_order_ref, 64'd0);
        chk("rst.price4", 64'(if4.price), 64'd0);
        chk("rst.cnt4",   64'(if4.replace_count), 64'd0);
        chk("rst.ds4",    64'(if4.desync_err), 64'd0);
        chk("rst.ov4",    64'(if4.overflow_err), 64'd0);
        chk("rst.valid8", 64'(if8.out_valid), 64'd0);
        rst = 1'b1;
        idle(1);

        // single 'U' followed by a 'D' starting at lane 3 of beat 7
        b = res4.size(); d0 = n_ds4; o0 = n_ov4;
        push_u(U1_OLD, U1_NEW, U1_SH, U1_PR);
        push_msg(8'h44, 9);
        send4(6, 1'b1, 0);
        chk("t1.pre", 64'(if4.out_valid), 64'd0);
        send4(1, 1'b0, 0);
        chk("t1.lat", 64'(if4.out_valid), 64'd1);
        send4(2, 1'b0, 0);
        idle(3);
        chk("t1.n", 64'(res4.size() - b), 64'd1);
        r = (res4.size() > b) ? res4[b] : '0;
        chk_res("t1", r, U1_OLD, U1_NEW, U1_SH, U1_PR);
        chk("t1.cnt", 64'(if4.replace_count), 64'd1);
        chk("t1.ds", 64'(n_ds4 - d0), 64'd0);
        chk("t1.ov", 64'(n_ov4 - o0), 64'd0);
        do_reset();

        // mixed stream at 8 lanes: A, U, X, U
        b = res8.size(); d0 = n_ds8;
        push_msg(8'h41, 36);
        push_u(U1_OLD, U1_NEW, U1_SH, U1_PR);
        push_msg(8'h58, 23);
        push_u(U2_OLD, U2_NEW, U2_SH, U2_PR);
        pad_to(8);
        send8(bq.size() / 8, 1'b1);
        idle(3);
        chk("t2.n", 64'(res8.size() - b), 64'd2);
        r = (res8.size() > b) ? res8[b] : '0;
        chk_res("t2.a", r, U1_OLD, U1_NEW, U1_SH, U1_PR);
        r = (res8.size() > b + 1) ? res8[b+1] : '0;
        chk_res("t2.b", r, U2_OLD, U2_NEW, U2_SH, U2_PR);
        chk("t2.cnt", 64'(if8.replace_count), 64'd2);
        chk("t2.ds", 64'(n_ds8 - d0), 64'd0);
        do_reset();

        // consumer stalled across two completions
        if4.out_ready = 1'b0;
        b = res4.size(); o0 = n_ov4;
        push_u(U1_OLD, U1_NEW, U1_SH, U1_PR);
        push_u(U2_OLD, U2_NEW, U2_SH, U2_PR);
        pad_to(4);
        send4(14, 1'b1, 0);
        chk("t3.ovpulse", 64'(if4.overflow_err), 64'd1);
        chk("t3.valid", 64'(if4.out_valid), 64'd1);
        chk("t3.old", if4.old_order_ref, U1_OLD);
        chk("t3.pr", 64'(if4.price), 64'(U1_PR));
        chk("t3.cnt", 64'(if4.replace_count), 64'd1);
        idle(2);
        chk("t3.ovn", 64'(n_ov4 - o0), 64'd1);
        if4.out_ready = 1'b1;
        idle(1);
        chk("t3.drop", 64'(if4.out_valid), 64'd0);
        chk("t3.n", 64'(res4.size() - b), 64'd1);
        do_reset();

        // unknown type 8'h7A at lane 2, garbage, then resync on sof
        b = res4.size(); d0 = n_ds4;
        push_msg(8'h44, 9);
        push_msg(8'h44, 9);
        bq.push_back(8'h7A);
        bq.push_back(8'h00);
        send4(5, 1'b1, 0);
        chk("t4.dspulse", 64'(if4.desync_err), 64'd1);
        push_u(U2_OLD, U2_NEW, U2_SH, U2_PR);
        pad_to(4);
        send4(7, 1'b0, 0);
        idle(2);
        chk("t4.quiet", 64'(res4.size() - b), 64'd0);
        chk("t4.qvalid", 64'(if4.out_valid), 64'd0);
        push_u(U1_OLD, U1_NEW, U1_SH, U1_PR);
        pad_to(4);
        send4(7, 1'b1, 0);
        idle(3);
        chk("t4.n", 64'(res4.size() - b), 64'd1);
        r = (res4.size() > b) ? res4[b] : '0;
        chk_res("t4", r, U1_OLD, U1_NEW, U1_SH, U1_PR);
        chk("t4.ds", 64'(n_ds4 - d0), 64'd1);
        do_reset();

        // sof at offset 12 of a 'U'
        b = res4.size(); d0 = n_ds4;
        push_u(U2_OLD, U2_NEW, U2_SH, U2_PR);
        send4(3, 1'b1, 0);
        bq.delete();
        push_u(U1_OLD, U1_NEW, U1_SH, U1_PR);
        pad_to(4);
        send4(7, 1'b1, 0);
        idle(3);
        chk("t5.n", 64'(res4.size() - b), 64'd1);
        r = (res4.size() > b) ? res4[b] : '0;
        chk_res("t5", r, U1_OLD, U1_NEW, U1_SH, U1_PR);
        chk("t5.ds", 64'(n_ds4 - d0), 64'd1);
        chk("t5.cnt", 64'(if4.replace_count), 64'd1);
        do_reset();

        // gapped beats, result held, then async reset mid second message
        if4.out_ready = 1'b0;
        d0 = n_ds4;
        push_u(U2_OLD, U2_NEW, U2_SH, U2_PR);
        push_u(U1_OLD, U1_NEW, U1_SH, U1_PR);
        pad_to(4);
        send4(7, 1'b1, 3);
        chk("t6.valid", 64'(if4.out_valid), 64'd1);
        chk("t6.old", if4.old_order_ref, U2_OLD);
        chk("t6.new", if4.new_order_ref, U2_NEW);
        chk("t6.sh", 64'(if4.shares), 64'(U2_SH));
        chk("t6.pr", 64'(if4.price), 64'(U2_PR));
        send4(3, 1'b0, 3);
        chk("t6.ds", 64'(n_ds4 - d0), 64'd0);
        #3 rst = 1'b0;
        #1;
        chk("t6.rvalid", 64'(if4.out_valid), 64'd0);
        chk("t6.rold", if4.old_order_ref, 64'd0);
        chk("t6.rnew", if4.new_order_ref, 64'd0);
        chk("t6.rsh", 64'(if4.shares), 64'd0);
        chk("t6.rcnt", 64'(if4.replace_count), 64'd0);
        rst = 1'b1;
        if4.out_ready = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
